// File: rtl/hcount_source.sv
// hcount_source: counting message generator on a 4-phase req/ack channel.
// The returning ack is synchronised and debounced before it steers the handshake FSM.
module hcount_source #(
    parameter int             ASZ       = 6,
    parameter int             DSZ       = 4,
    parameter int             RSZ       = 4,
    parameter int             ACK_CKS   = 4,
    parameter logic [ASZ-1:0] DST_ADDR  = ASZ'(5),
    parameter int             START_VAL = 0,
    parameter int             NUM_MSGS  = 8,
    parameter int             CSZ       = 16
) (
    input  logic                   gch_clk,
    input  logic                   gch_reset,
    output logic                   gch_ready,
    input  logic                   src_en,
    output logic                   snd0_req_out,
    input  logic                   snd0_ack,
    output logic [ASZ+DSZ+RSZ-1:0] snd0_data_out,
    output logic                   src_done,
    output logic [CSZ-1:0]         src_count
);
    localparam int W = ASZ + DSZ + RSZ;
    localparam int KW = (ACK_CKS > 1) ? $clog2(ACK_CKS) : 1;
    localparam logic [KW-1:0] KMAX = KW'(ACK_CKS - 1);

    typedef enum logic [2:0] {INIT, IDLE, SEND, RELEASE, DONE} state_t;

    state_t         state_q, state_d;
    logic           ack_m_q, ack_s_q, ckd_q, ckd_d;
    logic [KW-1:0]  deb_q, deb_d;
    logic [DSZ-1:0] dat_q, dat_d;
    logic [CSZ-1:0] count_q, count_d;
    logic [W-1:0]   word_q, word_d;
    logic           req_q, req_d, ready_q, ready_d, done_q, done_d;
    logic [RSZ-1:0] red;
    logic           start, finish;

    always_comb begin
        deb_d = (ack_s_q == ckd_q || deb_q == KMAX) ? '0 : deb_q + 1'b1;
        ckd_d = (ack_s_q != ckd_q && deb_q == KMAX) ? ack_s_q : ckd_q;
    end

    always_ff @(posedge gch_clk or negedge gch_reset) begin
        if (!gch_reset) state_q <= INIT;
        else            state_q <= state_d;
    end

    // A start also needs the synchroniser empty, so an ack already high at reset release cannot slip through before ckd_ack catches up.
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = IDLE;
            IDLE:    state_d = (NUM_MSGS != 0 && count_q == CSZ'(NUM_MSGS)) ? DONE :
                               (src_en && !ack_m_q && !ack_s_q && !ckd_q) ? SEND : IDLE;
            SEND:    state_d = ckd_d ? RELEASE : SEND;
            RELEASE: state_d = ckd_q ? RELEASE : IDLE;
            default: state_d = DONE;
        endcase
    end

    always_comb begin
        start   = state_q == IDLE && state_d == SEND;
        finish  = state_q == RELEASE && state_d == IDLE;
        red     = RSZ'(DST_ADDR) + RSZ'(dat_q);
        word_d  = start ? {DST_ADDR, dat_q, red} : word_q;
        dat_d   = finish ? dat_q + 1'b1 : dat_q;
        count_d = (finish && count_q != '1) ? count_q + 1'b1 : count_q;
        req_d   = state_d == SEND;
        ready_d = state_d != INIT;
        done_d  = state_d == DONE;
    end

    always_ff @(posedge gch_clk or negedge gch_reset) begin
        if (!gch_reset) begin
            ack_m_q <= 1'b0;
            ack_s_q <= 1'b0;
            ckd_q   <= 1'b0;
            deb_q   <= '0;
            dat_q   <= DSZ'(START_VAL);
            count_q <= '0;
            word_q  <= '0;
            req_q   <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ack_m_q <= snd0_ack;
            ack_s_q <= ack_m_q;
            ckd_q   <= ckd_d;
            deb_q   <= deb_d;
            dat_q   <= dat_d;
            count_q <= count_d;
            word_q  <= word_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign gch_ready     = ready_q;
    assign snd0_req_out  = req_q;
    assign snd0_data_out = word_q;
    assign src_done      = done_q;
    assign src_count     = count_q;
endmodule

// File: tb/tb_hcount_source.sv
// tb_hcount_source: directed bench for hcount_source, default and unbounded/wrapping configurations.
module tb_hcount_source;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0_n, rst1_n, en0, en1, ack0, ack1;
    logic        rdy0, req0, done0, rdy1, req1, done1;
    logic [13:0] data0, data1;
    logic [15:0] cnt0, cnt1;
    logic        prev;
    int          n;
    int          total = 0;
    int          bad = 0;

    logic [13:0] exp0 [8] = '{14'h0505, 14'h0516, 14'h0527, 14'h0538,
                              14'h0549, 14'h055A, 14'h056B, 14'h057C};
    logic [13:0] exp1 [4] = '{14'h05E3, 14'h05F4, 14'h0505, 14'h0516};

    hcount_source u0 (
        .gch_clk(clk), .gch_reset(rst0_n), .gch_ready(rdy0), .src_en(en0),
        .snd0_req_out(req0), .snd0_ack(ack0), .snd0_data_out(data0),
        .src_done(done0), .src_count(cnt0)
    );

    hcount_source #(.NUM_MSGS(0), .START_VAL(14)) u1 (
        .gch_clk(clk), .gch_reset(rst1_n), .gch_ready(rdy1), .src_en(en1),
        .snd0_req_out(req1), .snd0_ack(ack1), .snd0_data_out(data1),
        .src_done(done1), .src_count(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic wait_req0(input logic lvl, input int budget, input string tag);
        for (int i = 0; i < budget && req0 !== lvl; i++) @(negedge clk);
        check(tag, 32'(req0), 32'(lvl));
    endtask

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        en0 = 1'b0; en1 = 1'b0; ack0 = 1'b0; ack1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst ready", 32'(rdy0), 0);
        check("rst req", 32'(req0), 0);
        check("rst data", 32'(data0), 0);
        check("rst done", 32'(done0), 0);
        check("rst count", 32'(cnt0), 0);
        check("rst1 req", 32'(req1), 0);

        // eight messages with a prompt consumer, then stop
        en0 = 1'b1; rst0_n = 1'b1; prev = 1'b0; n = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 0) check("ready after release", 32'(rdy0), 1);
            if (req0 && !prev) begin
                if (n < 8) check($sformatf("msg%0d", n), 32'(data0), 32'(exp0[n]));
                n++;
            end
            prev = req0;
            ack0 = req0;
        end
        check("msg total", n, 8);
        check("done", 32'(done0), 1);
        check("count", 32'(cnt0), 8);
        check("req after done", 32'(req0), 0);

        // short ack glitch ignored, a real ack drops req six edges later
        rst0_n = 1'b0; ack0 = 1'b0;
        @(negedge clk);
        rst0_n = 1'b1;
        wait_req0(1'b1, 20, "glitch req rise");
        check("glitch data", 32'(data0), 32'(exp0[0]));
        ack0 = 1'b1;
        repeat (3) @(negedge clk);
        ack0 = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch ignored", 32'(req0), 1);
        ack0 = 1'b1;
        repeat (5) @(negedge clk);
        check("req held 5", 32'(req0), 1);
        @(negedge clk);
        check("req fall 6", 32'(req0), 0);
        ack0 = 1'b0;
        wait_req0(1'b1, 20, "second req rise");
        check("second count", 32'(cnt0), 1);
        check("second data", 32'(data0), 32'(exp0[1]));

        // src_en dropped mid-message: it completes, nothing new starts
        en0 = 1'b0; ack0 = 1'b1;
        wait_req0(1'b0, 20, "en drop req fall");
        ack0 = 1'b0;
        repeat (30) @(negedge clk);
        check("en low no req", 32'(req0), 0);
        check("en low count", 32'(cnt0), 2);
        en0 = 1'b1;
        wait_req0(1'b1, 20, "en resume req");
        check("resume data", 32'(data0), 32'(exp0[2]));

        // asynchronous reset while req is high
        #2 rst0_n = 1'b0;
        #1;
        check("async req", 32'(req0), 0);
        check("async count", 32'(cnt0), 0);
        check("async ready", 32'(rdy0), 0);
        @(negedge clk);
        rst0_n = 1'b1;
        wait_req0(1'b1, 20, "restart req");
        check("restart data", 32'(data0), 32'(exp0[0]));

        // ack stuck high through reset release
        rst0_n = 1'b0; ack0 = 1'b1;
        repeat (3) @(negedge clk);
        rst0_n = 1'b1;
        @(negedge clk);
        check("stuck ready", 32'(rdy0), 1);
        check("stuck req", 32'(req0), 0);
        repeat (10) @(negedge clk);
        check("stuck blocked", 32'(req0), 0);
        ack0 = 1'b0;
        repeat (6) @(negedge clk);
        check("stuck req at 6", 32'(req0), 0);
        @(negedge clk);
        check("stuck req at 7", 32'(req0), 1);
        check("stuck data", 32'(data0), 32'(exp0[0]));

        // unbounded instance starting at 14: data wraps, never done
        en1 = 1'b1; rst1_n = 1'b1; prev = 1'b0; n = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (req1 && !prev) begin
                if (n < 4) begin
                    check($sformatf("u1 msg%0d", n), 32'(data1), 32'(exp1[n]));
                    check($sformatf("u1 count%0d", n), 32'(cnt1), n);
                end
                n++;
            end
            prev = req1;
            ack1 = req1;
        end
        check("u1 enough msgs", 32'(n >= 4), 1);
        check("u1 not done", 32'(done1), 0);
        check("u1 ready", 32'(rdy1), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
